// File: rtl/spi16_master.sv
// 16-bit full-duplex SPI master: SCLK = clk/32, idles high, MOSI launched on falls,
// MISO sampled just before each rise. done is sticky until the next accepted wrt.
module spi16_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  typedef enum logic [1:0] {IDLE, FRONT, SHIFT, BACK} state_t;

  state_t      state_q, state_d;
  logic [15:0] shft_q, shft_d;
  logic [4:0]  div_q, div_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        miso_smpl_q, miso_smpl_d;
  logic        done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shft_q      <= 16'h0000;
      div_q       <= 5'd0;
      bit_cnt_q   <= 5'd0;
      miso_smpl_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shft_q      <= shft_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      miso_smpl_q <= miso_smpl_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shft_d      = shft_q;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    miso_smpl_d = miso_smpl_q;
    done_d      = done_q;
    case (state_q)
      IDLE: begin
        if (wrt) begin
          shft_d    = cmd;
          div_d     = 5'b10111;
          bit_cnt_d = 5'd0;
          done_d    = 1'b0;
          state_d   = FRONT;
        end
      end
      FRONT: begin
        div_d = div_q + 5'd1;
        if (div_q == 5'b11111) state_d = SHIFT;
      end
      SHIFT: begin
        div_d = div_q + 5'd1;
        if (div_q == 5'b01111) miso_smpl_d = MISO;
        // Shift coincides with the SCLK fall; the last shift parks div so SCLK stays high.
        if (div_q == 5'b11111) begin
          shft_d    = {shft_q[14:0], miso_smpl_q};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd15) begin
            div_d   = 5'b11111;
            state_d = BACK;
          end
        end
      end
      BACK: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign SS_n    = (state_q == IDLE);
  assign SCLK    = ((state_q == FRONT) || (state_q == SHIFT)) ? div_q[4] : 1'b1;
  assign MOSI    = shft_q[15];
  assign rd_data = shft_q;
  assign done    = done_q;

endmodule
